// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: frames parallel bytes as start/data/parity/stop bits,
// timing each bit by counting rising edges of the oversampled baud reference.
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = 4
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic                 baud_in,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 two_stop,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } state_t;

    state_t                 state_q;
    logic                   baud_prev_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [IDX_W-1:0]       idx_d;
    logic [DATA_BITS-1:0]   shadow_q;
    logic                   parity_q;
    logic                   par_en_q;
    logic                   two_stop_q;
    logic                   tx_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   baud_tick;
    logic                   bit_end;

    assign baud_tick = baud_in & ~baud_prev_q;
    assign bit_end   = baud_tick & (cnt_q == CNT_W'(OVERSAMPLE - 1));
    assign idx_d     = idx_q + 1'b1;

    // Reset is folded in so the handshake stays closed while reset is held.
    assign tx_ready  = (state_q == ST_IDLE) & Enable & Reset;

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_IDLE;
            baud_prev_q <= 1'b1;
            cnt_q       <= '0;
            idx_q       <= '0;
            shadow_q    <= '0;
            parity_q    <= 1'b0;
            par_en_q    <= 1'b0;
            two_stop_q  <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            baud_prev_q <= baud_in;
            done_q      <= 1'b0;
            if (state_q == ST_IDLE) begin
                cnt_q <= '0;
                if (tx_valid && tx_ready) begin
                    shadow_q   <= tx_data;
                    parity_q   <= (^tx_data) ^ parity_odd;
                    par_en_q   <= parity_en;
                    two_stop_q <= two_stop;
                    idx_q      <= '0;
                    state_q    <= ST_START;
                    tx_q       <= 1'b0;
                    busy_q     <= 1'b1;
                end
            end else if (baud_tick) begin
                cnt_q <= bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    unique case (state_q)
                        ST_START: begin
                            state_q <= ST_DATA;
                            tx_q    <= shadow_q[0];
                        end
                        ST_DATA: begin
                            if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                                state_q <= par_en_q ? ST_PARITY : ST_STOP1;
                                tx_q    <= par_en_q ? parity_q : 1'b1;
                            end else begin
                                idx_q <= idx_d;
                                tx_q  <= shadow_q[idx_d];
                            end
                        end
                        ST_PARITY: begin
                            state_q <= ST_STOP1;
                            tx_q    <= 1'b1;
                        end
                        ST_STOP1: begin
                            if (two_stop_q) begin
                                state_q <= ST_STOP2;
                            end else begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end
                        ST_STOP2: begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                        default: begin
                            state_q <= ST_IDLE;
                            tx_q    <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: table-driven frames, a bit-level
// scoreboard monitor, and hand-written back-to-back / enable / reset sequences.
module tb_uart_tx_serializer;

    localparam int BITCLK = 64;  // 16 baud edges x 4 clocks per edge

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       baud_in = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       pe, po, ts;
    logic       tx, busy, tx_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.DATA_BITS(8), .OVERSAMPLE(16), .CNT_W(4)) dut (
        .Clock(clk), .Reset(rst_n), .Enable(en), .baud_in(baud_in),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .parity_en(pe), .parity_odd(po), .two_stop(ts),
        .tx(tx), .busy(busy), .tx_done(tx_done)
    );

    // Baud reference: high one clock in four, or stuck high on request.
    int   div = 0;
    logic baud_stuck = 1'b0;
    always @(negedge clk) begin
        if (baud_stuck) baud_in = 1'b1;
        else begin
            div     = (div + 1) % 4;
            baud_in = (div == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d..%0d at %0t", name, act, lo, hi, $time);
        end
    endtask

    typedef struct {
        logic [11:0] bits;
        int          n;
    } frame_t;

    frame_t sb[$];

    function automatic frame_t build(input logic [7:0] d, input logic pe_, input logic ts_,
                                     input logic par);
        frame_t f;
        f.bits    = '1;
        f.bits[0] = 1'b0;
        f.n       = 1;
        for (int i = 0; i < 8; i++) begin
            f.bits[f.n] = d[i];
            f.n++;
        end
        if (pe_) begin
            f.bits[f.n] = par;
            f.n++;
        end
        f.bits[f.n] = 1'b1;
        f.n++;
        if (ts_) begin
            f.bits[f.n] = 1'b1;
            f.n++;
        end
        return f;
    endfunction

    // Monitor: frame starts on a falling tx edge, each bit sampled mid-period.
    bit     mon_en   = 1'b1;
    bit     in_frame = 1'b0;
    logic   prev_tx  = 1'b1;
    int     mpos     = 0;
    frame_t cur;
    always @(negedge clk) begin
        if (!rst_n || !mon_en) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (tx_done === 1'b1) begin
                n_checks++;
                n_errors++;
                $display("FAIL spurious_done: got 1 expected 0 at %0t", $time);
            end
            if (tx === 1'b0 && prev_tx === 1'b1) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_frame: got start bit expected idle at %0t", $time);
                end else begin
                    cur      = sb.pop_front();
                    in_frame = 1'b1;
                    mpos     = 0;
                end
            end
        end else begin
            mpos++;
            if (mpos % BITCLK == BITCLK / 2 && mpos / BITCLK < cur.n) begin
                check($sformatf("frame_bit%0d", mpos / BITCLK), tx, cur.bits[mpos / BITCLK]);
                check("busy_in_frame", busy, 1);
                check("ready_in_frame", tx_ready, 0);
            end
            if (tx_done === 1'b1 || mpos > BITCLK * cur.n + 8) in_frame = 1'b0;
        end
        prev_tx = tx;
    end

    task automatic drive(input logic [7:0] d, input logic pe_, input logic po_, input logic ts_,
                         input logic par);
        tx_data  = d;
        pe       = pe_;
        po       = po_;
        ts       = ts_;
        sb.push_back(build(d, pe_, ts_, par));
        tx_valid = 1'b1;
    endtask

    // Returns at the negedge after the accepting posedge.
    task automatic wait_accept(input string name, output logic done_seen);
        int k;
        k = 0;
        #1;
        while (tx_ready !== 1'b1 && k < 3000) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(name, tx_ready, 1);
        done_seen = tx_done;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_done(input string name, input int nbits, input int k0);
        int k;
        k = k0;
        while (k < BITCLK * nbits + 40) begin
            @(negedge clk);
            k++;
            if (tx_done === 1'b1) break;
        end
        check_range(name, k, BITCLK * nbits - 4, BITCLK * nbits + 4);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       pe, po, ts;
        logic       exp_par;
        int         exp_bits;
    } vec_t;

    vec_t vecs[7];

    initial begin : watchdog
        #2ms;
        n_checks++;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        logic ds;
        int   k;
        int   bad;

        vecs[0] = '{8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 10};
        vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 11};
        vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 11};
        vecs[3] = '{8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 12};
        vecs[4] = '{8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 11};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 12};
        vecs[6] = '{8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 11};

        rst_n = 1'b0; en = 1'b1; tx_valid = 1'b0; tx_data = '0;
        pe = 1'b0; po = 1'b0; ts = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_ready", tx_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", tx_done, 0);
        rst_n = 1'b1;
        #1;
        check("idle_ready", tx_ready, 1);
        repeat (5) @(negedge clk);
        check("idle_tx", tx, 1);

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].data, vecs[i].pe, vecs[i].po, vecs[i].ts, vecs[i].exp_par);
            wait_accept("accept", ds);
            tx_valid = 1'b0;
            wait_done($sformatf("frame_len_v%0d", i), vecs[i].exp_bits, 0);
            @(negedge clk);
            check("done_one_cycle", tx_done, 0);
            check("post_tx_idle", tx, 1);
            check("post_busy", busy, 0);
            repeat (5) @(negedge clk);
        end

        // Back-to-back: second byte taken in the tx_done cycle with no idle gap.
        drive(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_accept("b2b_accept1", ds);
        drive(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_accept("b2b_accept2", ds);
        check("b2b_ready_in_done_cycle", ds, 1);
        check("b2b_no_gap_tx", tx, 0);
        check("b2b_no_gap_busy", busy, 1);
        tx_valid = 1'b0;
        wait_done("b2b_frame2_len", 10, 0);
        repeat (5) @(negedge clk);

        // Enable dropped mid-frame: frame completes, pending byte held off.
        drive(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_accept("en_accept", ds);
        tx_data = 8'h81;
        repeat (4 * BITCLK + BITCLK / 2) @(negedge clk);
        en = 1'b0;
        wait_done("en_drop_done", 10, 4 * BITCLK + BITCLK / 2);
        bad = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (tx_ready !== 1'b0 || busy !== 1'b0 || tx !== 1'b1) bad++;
        end
        check_range("en_blocked_cycles", bad, 0, 0);
        sb.push_back(build(8'h81, 1'b0, 1'b0, 1'b0));
        en = 1'b1;
        wait_accept("en_reaccept", ds);
        tx_valid = 1'b0;
        wait_done("en_reaccept_len", 10, 0);
        repeat (5) @(negedge clk);

        // Reset during data bit 4: immediate idle line, frame abandoned.
        drive(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_accept("rst_accept", ds);
        tx_valid = 1'b0;
        repeat (5 * BITCLK + BITCLK / 2) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", tx_done, 0);
        check("async_rst_ready", tx_ready, 0);
        @(negedge clk);
        baud_stuck = 1'b1;
        repeat (3) @(negedge clk);
        mon_en = 1'b0;
        rst_n  = 1'b1;

        // baud_in held high across release: no edge counted until it toggles.
        tx_data = 8'hFF; pe = 1'b0; ts = 1'b0; tx_valid = 1'b1;
        wait_accept("stuck_accept", ds);
        tx_valid = 1'b0;
        repeat (40) @(negedge clk);
        check("stuck_tx_held", tx, 0);
        check("stuck_busy_held", busy, 1);
        baud_stuck = 1'b0;
        k = 0;
        while (tx !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_range("first_bit_after_stuck", k, 56, 76);
        k = 0;
        while (tx_done !== 1'b1 && k < 1000) begin
            @(negedge clk);
            k++;
        end
        check("stuck_frame_done", tx_done, 1);
        @(negedge clk);
        mon_en = 1'b1;

        repeat (10) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
UART transmit stage directly downstream of the baud rate generator. It consumes the generator's baud_out level as an oversampled timing reference and accepts parallel bytes over a ready/valid handshake. Each byte is serialized as start, data (LSB first), optional parity and 1 or 2 stop bits on the tx line. It sits between the SoC bus-side transmit logic and the external serial pin.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..8)
OVERSAMPLE, 16, baud_in rising edges per serial bit period (>=2)
CNT_W, 4, width of oversample counter; must satisfy 2^CNT_W >= OVERSAMPLE

Ports:
Clock  input  1  system clock; all state on rising edge
Reset  input  1  asynchronous, active-low reset
Enable  input  1  1 = new frames may be accepted
baud_in  input  1  baud_out level from baud rate generator, synchronous to Clock
tx_data  input  DATA_BITS  byte to send
tx_valid  input  1  tx_data valid
tx_ready  output  1  block can accept a byte this cycle
parity_en  input  1  1 = insert parity bit
parity_odd  input  1  1 = odd parity, 0 = even (ignored if parity_en=0)
two_stop  input  1  1 = two stop bits, 0 = one
tx  output  1  serial output, idle high
busy  output  1  frame in progress
tx_done  output  1  one-cycle pulse when last stop bit completes

Behaviour:
- Reset (async, Reset=0): tx=1, tx_ready=0 while asserted, busy=0, tx_done=0, state=IDLE, counters=0, baud_prev=1. The baud_prev=1 value ensures a high baud_in at release is not counted as an edge.
- Baud edge: baud_tick = baud_in & ~baud_prev. baud_prev is registered every cycle.
- tx_ready = (state==IDLE) & Enable. This is combinational from registered state.
- Acceptance happens on a rising Clock edge with tx_valid & tx_ready. On acceptance:
  - latch tx_data, parity_en, parity_odd, two_stop into shadow registers; input changes during the frame have no effect
  - compute parity = ^data XOR parity_odd
  - state moves to START, tx=0 and busy=1 from the next cycle
  - oversample counter cleared
  - a baud_tick in the acceptance cycle is not counted
- FSM states: IDLE -> START -> DATA -> (PARITY if parity_en) -> STOP1 -> (STOP2 if two_stop) -> IDLE.
- Bit timing: in each non-IDLE state, the counter increments on baud_tick. The state advances on the baud_tick where counter==OVERSAMPLE-1, and the counter wraps to 0 on that tick. Each bit therefore lasts exactly OVERSAMPLE baud edges.
- DATA: bit index 0..DATA_BITS-1. tx = shadow[index], LSB first. Leave DATA when index==DATA_BITS-1 completes.
- Line values: PARITY tx=parity; STOP1/STOP2 tx=1; IDLE tx=1.
- tx_done: asserted for exactly one cycle, the cycle after the final stop bit's terminating tick. This is the same cycle state returns to IDLE and busy=0. tx_ready may be 1 in that same cycle (if Enable=1), so back-to-back frames are allowed with no idle bit gap.
- Enable deasserted mid-frame: the current frame completes normally; only new acceptance is blocked.
- tx_valid with Enable=0: ignored; data must be held by the source until tx_ready.
- baud_in stuck (no edges): block holds its current state and tx value indefinitely; no timeout.
- Reset mid-frame: tx returns to 1 immediately (async). The frame is abandoned and no tx_done is issued.
- Outputs tx, busy and tx_done are registered (glitch-free). tx_ready is combinational as defined above.

Test Plan:
1. Default params, baud_in pulses high 1 of every 4 clocks, send 0x55 with parity_en=0, two_stop=0 -> tx sequence 0,1,0,1,0,1,0,1,0,1 each held 16 edges (64±4 clocks); tx_done one pulse about 640 clocks after acceptance; tx=1 after.
2. Send 0x07 with parity_en=1, parity_odd=0 -> parity bit 1. Repeat with parity_odd=1 -> parity bit 0. Frame length 11 bit periods.
3. Send 0xA5 with two_stop=1, parity_en=1, even parity -> bits 0,1,0,1,0,0,1,0,1,0(parity),1,1. busy high for 12 bit periods.
4. Hold tx_valid=1 with 0xA5 then 0x3C -> second byte accepted in the tx_done cycle; its start bit begins with no idle gap; tx_ready low throughout each frame.
5. Drop Enable after bit 3 of 0xF0 -> frame completes with tx_done; tx_ready stays 0 and a pending tx_valid is not accepted until Enable=1.
6. Assert Reset during DATA bit 4 -> tx=1, busy=0 same cycle. No tx_done. After release, with baud_in=1, the first counted edge is the next genuine 0->1 transition.
